// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: ARM LDM/STM block-transfer sequencer feeding the register file.
// Define LDM_ABORT_EN to add a mem_abort input that ends a transfer with err.
module ldm_stm_seq #(
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic [3:0]  base_sel,
  input  logic [31:0] base_val,
  input  logic        load,
  input  logic        up,
  input  logic        pre,
  input  logic        wb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  sel_in,
  output logic [31:0] in_reg,
  output logic        rf_not_enable,
  output logic [3:0]  sel_p0,
  input  logic [31:0] p0,
  input  logic [3:0]  flags_cur,
  output logic [3:0]  flags_out,
  input  logic [31:0] pc_in,
  output logic        pc_we,
  output logic [31:0] pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef LDM_ABORT_EN
  input  logic        mem_abort,
`endif
  input  logic        mem_ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RDSEL = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] wait_q, wait_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [3:0]  bsel_q;
  logic        load_q, up_q, pre_q, wb_q, bil_q;

  logic [3:0]  idx;
  logic [15:0] rest;
  logic [4:0]  cnt;
  logic [31:0] n4;
  logic [31:0] src;
  logic [2:0]  fin;
  logic        abort;
  logic        tmo;

  // Lowest set bit of the remaining list is the register in flight.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (list_q[i]) idx = 4'(i);
  end

  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 16; i++)
      cnt = cnt + {4'd0, list_q[i]};
  end

  assign rest = list_q & ~(16'd1 << idx);
  assign n4   = {25'd0, cnt, 2'b00};
  assign src  = (idx == 4'd15) ? pc_in : p0;
  assign fin  = (wb_q && !(load_q && bil_q)) ? S_WB : S_DONE;
  assign tmo  = (ACK_TIMEOUT != 0) && (wait_q == ACK_TIMEOUT - 1);

`ifdef LDM_ABORT_EN
  assign abort = mem_abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bsel_q <= 4'd0;
      load_q <= 1'b0;
      up_q   <= 1'b0;
      pre_q  <= 1'b0;
      wb_q   <= 1'b0;
      bil_q  <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      bsel_q <= base_sel;
      load_q <= load;
      up_q   <= up;
      pre_q  <= pre;
      wb_q   <= wb;
      bil_q  <= reg_list[base_sel];
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wait_d  = wait_q;
    first_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (start) begin
          state_d = S_SETUP;
          list_d  = reg_list;
          base_d  = base_val;
        end
      end
      S_SETUP: begin
        case ({up_q, pre_q})
          2'b10:   addr_d = base_q;
          2'b11:   addr_d = base_q + 32'd4;
          2'b00:   addr_d = base_q - n4 + 32'd4;
          default: addr_d = base_q - n4;
        endcase
        // base_q now holds the final (written-back) base
        base_d = up_q ? base_q + n4 : base_q - n4;
        wait_d = 32'd0;
        if (cnt == 5'd0)  state_d = S_DONE;
        else if (load_q)  state_d = S_MEM;
        else              state_d = S_RDSEL;
      end
      S_RDSEL: begin
        state_d = S_MEM;
        first_d = 1'b1;
      end
      S_MEM: begin
        if (first_q && !load_q) data_d = src;
        if (mem_ack && abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mem_ack) begin
          addr_d = addr_q + 32'd4;
          wait_d = 32'd0;
          if (load_q) begin
            data_d  = mem_rdata;
            state_d = S_WRITE;
          end else begin
            list_d  = rest;
            state_d = (rest == 16'd0) ? fin : S_RDSEL;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WRITE: begin
        list_d  = rest;
        state_d = (rest == 16'd0) ? fin : S_MEM;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      list_q  <= 16'd0;
      base_q  <= 32'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wait_q  <= 32'd0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sel_in        = 4'd0;
    in_reg        = 32'd0;
    rf_not_enable = 1'b1;
    pc_we         = 1'b0;
    pc_data       = 32'd0;
    unique case (1'b1)
      (state_q == S_WRITE) && (idx == 4'd15): begin
        pc_we   = 1'b1;
        pc_data = data_q & ~32'd3;
      end
      (state_q == S_WRITE) && (idx != 4'd15): begin
        rf_not_enable = 1'b0;
        sel_in        = idx;
        in_reg        = data_q;
      end
      (state_q == S_WB): begin
        rf_not_enable = 1'b0;
        sel_in        = bsel_q;
        in_reg        = base_q;
      end
      default: ;
    endcase
  end

  // Store data is taken live from p0 on the first MEM cycle, then held.
  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = mem_req && !load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? (first_q ? src : data_q) : 32'd0;
  assign sel_p0    = (state_q == S_RDSEL) ? idx : 4'd0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;
  assign flags_out = flags_cur;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: directed bench for the LDM/STM sequencer with a
// register-file model and a req/ack memory responder; ACK_TIMEOUT=8.
module tb_ldm_stm_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_sel = '0;
  logic [31:0] base_val = '0;
  logic        load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wb = 1'b0;
  logic        busy, done, err;
  logic [3:0]  sel_in;
  logic [31:0] in_reg;
  logic        rf_not_enable;
  logic [3:0]  sel_p0;
  logic [31:0] p0 = '0;
  logic [3:0]  flags_cur = 4'h5;
  logic [3:0]  flags_out;
  logic [31:0] pc_in = 32'hC0DE_0004;
  logic        pc_we;
  logic [31:0] pc_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef LDM_ABORT_EN
  logic        mem_abort = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 0;
  int wcnt = 0;
  int nacc = 0;
  int nreq = 0;
  int nwr = 0;
  int npc = 0;
  logic [31:0] pc_last = '0;
  logic [31:0] rf [16];
  logic [31:0] rd_tab [4];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] lg_addr [$];
  logic [31:0] lg_wd [$];
  logic        lg_we [$];

  ldm_stm_seq #(.ACK_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .reg_list(reg_list), .base_sel(base_sel),
    .base_val(base_val), .load(load), .up(up),
    .pre(pre), .wb(wb), .busy(busy), .done(done),
    .err(err), .sel_in(sel_in), .in_reg(in_reg),
    .rf_not_enable(rf_not_enable), .sel_p0(sel_p0),
    .p0(p0), .flags_cur(flags_cur),
    .flags_out(flags_out), .pc_in(pc_in),
    .pc_we(pc_we), .pc_data(pc_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef LDM_ABORT_EN
    .mem_abort(mem_abort),
`endif
    .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  assign mem_ack = mem_req && (ack_dly >= 0) && (wcnt >= ack_dly);
  assign mem_rdata = rd_tab[nacc[1:0]];

  always @(posedge clock or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (mem_req) wcnt <= mem_ack ? 0 : wcnt + 1;
  end

  always @(posedge clock) begin
    if (pre_en) rf[pre_idx] <= pre_val;
    p0 <= rf[sel_p0];
    if (!reset) begin
      if (!rf_not_enable) begin
        rf[sel_in] <= in_reg;
        nwr <= nwr + 1;
      end
      if (mem_req) nreq <= nreq + 1;
      if (mem_req && mem_ack) begin
        nacc <= nacc + 1;
        lg_addr.push_back(mem_addr);
        lg_wd.push_back(mem_wdata);
        lg_we.push_back(mem_we);
      end
      if (pc_we) begin
        npc <= npc + 1;
        pc_last <= pc_data;
      end
    end
  end

  task automatic rf_set(input logic [3:0] i, input logic [31:0] v);
    @(negedge clock);
    pre_en = 1'b1; pre_idx = i; pre_val = v;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic launch(input logic [15:0] lst, input logic [3:0] bs,
                        input logic [31:0] bv, input logic ld, u, p, w,
                        output int cyc, output logic e, output logic bok);
    int g;
    g = 0;
    @(negedge clock);
    while (busy && g < 50) begin @(negedge clock); g++; end
    reg_list = lst; base_sel = bs; base_val = bv;
    load = ld; up = u; pre = p; wb = w; start = 1'b1;
    cyc = 0; e = 1'b0; bok = 1'b1;
    while (cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      if (!busy) bok = 1'b0;
      if (done) begin e = err; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clock); #1;
    n_chk++;
    if ({busy, done, err, mem_req, mem_we, pc_we, rf_not_enable} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000001",
        {busy, done, err, mem_req, mem_we, pc_we, rf_not_enable});
    end
    n_chk++;
    if ({mem_addr, mem_wdata, in_reg, pc_data} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, in_reg, pc_data});
    end
    n_chk++;
    if ({sel_in, sel_p0} !== 8'd0) begin
      n_fail++; $display("FAIL reset_sel: got %h want 00", {sel_in, sel_p0});
    end
    n_chk++;
    if (flags_out !== 4'h5) begin
      n_fail++; $display("FAIL reset_flags: got %h want 5", flags_out);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_stm_ia;
    int cyc, a0;
    logic e, bok;
    rf_set(0, 32'hA); rf_set(1, 32'hB); rf_set(2, 32'hC); rf_set(4, 32'h1000);
    ack_dly = 0;
    a0 = lg_addr.size();
    launch(16'h0007, 4'd4, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b1, cyc, e, bok);
    n_chk++;
    if (cyc !== 9) begin n_fail++; $display("FAIL stm_ia_latency: got %0d want 9", cyc); end
    n_chk++;
    if (lg_addr.size() - a0 !== 3) begin
      n_fail++; $display("FAIL stm_ia_count: got %0d want 3", lg_addr.size() - a0);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (lg_addr[a0+i] !== 32'h1000 + 32'(4*i) || lg_we[a0+i] !== 1'b1 ||
          lg_wd[a0+i] !== 32'hA + 32'(i)) begin
        n_fail++;
        $display("FAIL stm_ia_xfer%0d: got a=%h we=%b d=%h want a=%h we=1 d=%h", i,
          lg_addr[a0+i], lg_we[a0+i], lg_wd[a0+i], 32'h1000 + 32'(4*i), 32'hA + 32'(i));
      end
    end
    n_chk++;
    if (rf[4] !== 32'h100C) begin n_fail++; $display("FAIL stm_ia_wb: got %h want 100c", rf[4]); end
    n_chk++;
    if (e !== 1'b0 || bok !== 1'b1) begin
      n_fail++; $display("FAIL stm_ia_status: err %b busy_ok %b want 0 1", e, bok);
    end
    @(posedge clock); #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stm_ia_pulse: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_ldm_db;
    int cyc, a0, p0c, b;
    logic e, bok;
    rf_set(4, 32'h2000); rf_set(15, 32'hDEAD_BEEF);
    rf_set(0, 32'h0); rf_set(1, 32'h0);
    b = nacc;
    rd_tab[(b+0)&3] = 32'h11; rd_tab[(b+1)&3] = 32'h22; rd_tab[(b+2)&3] = 32'h1237;
    a0 = lg_addr.size(); p0c = npc;
    launch(16'h8003, 4'd4, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, cyc, e, bok);
    n_chk++;
    if (cyc !== 8) begin n_fail++; $display("FAIL ldm_db_latency: got %0d want 8", cyc); end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (lg_addr[a0+i] !== 32'h1FF4 + 32'(4*i) || lg_we[a0+i] !== 1'b0) begin
        n_fail++;
        $display("FAIL ldm_db_addr%0d: got %h we=%b want %h we=0", i,
          lg_addr[a0+i], lg_we[a0+i], 32'h1FF4 + 32'(4*i));
      end
    end
    n_chk++;
    if (rf[0] !== 32'h11 || rf[1] !== 32'h22) begin
      n_fail++; $display("FAIL ldm_db_regs: got %h %h want 11 22", rf[0], rf[1]);
    end
    n_chk++;
    if (npc - p0c !== 1 || pc_last !== 32'h1234) begin
      n_fail++; $display("FAIL ldm_db_pc: got %0d x %h want 1 x 1234", npc - p0c, pc_last);
    end
    n_chk++;
    if (rf[15] !== 32'hDEAD_BEEF || rf[4] !== 32'h2000) begin
      n_fail++; $display("FAIL ldm_db_untouched: r15 %h r4 %h want deadbeef 2000", rf[15], rf[4]);
    end
    n_chk++;
    if (flags_out !== 4'h5) begin n_fail++; $display("FAIL ldm_db_flags: got %h want 5", flags_out); end
  endtask

  task automatic test_ldm_base_in_list;
    int cyc, a0, w0;
    logic e, bok;
    rf_set(2, 32'h3000);
    rd_tab[nacc & 3] = 32'h55;
    a0 = lg_addr.size(); w0 = nwr;
    launch(16'h0004, 4'd2, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, cyc, e, bok);
    n_chk++;
    if (cyc !== 4) begin n_fail++; $display("FAIL ldm_bil_latency: got %0d want 4", cyc); end
    n_chk++;
    if (rf[2] !== 32'h55 || nwr - w0 !== 1) begin
      n_fail++; $display("FAIL ldm_bil_reg: r2 %h writes %0d want 55 1", rf[2], nwr - w0);
    end
    n_chk++;
    if (lg_addr[a0] !== 32'h3000) begin
      n_fail++; $display("FAIL ldm_bil_addr: got %h want 3000", lg_addr[a0]);
    end
  endtask

  task automatic test_empty_list;
    int cyc, r0, w0;
    logic e, bok;
    r0 = nreq; w0 = nwr;
    launch(16'h0000, 4'd3, 32'h7000, 1'b0, 1'b1, 1'b0, 1'b1, cyc, e, bok);
    n_chk++;
    if (cyc !== 2) begin n_fail++; $display("FAIL empty_latency: got %0d want 2", cyc); end
    n_chk++;
    if (nreq - r0 !== 0 || nwr - w0 !== 0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_activity: req %0d wr %0d err %b want 0 0 0", nreq - r0, nwr - w0, e);
    end
  endtask

  task automatic test_ack_wait;
    int cyc, a0, r0;
    logic e, bok;
    rf_set(5, 32'h5555); rf_set(0, 32'h0BAD);
    ack_dly = 7;
    a0 = lg_addr.size(); r0 = nreq;
    launch(16'h0020, 4'd9, 32'h8000, 1'b0, 1'b1, 1'b1, 1'b0, cyc, e, bok);
    ack_dly = 0;
    n_chk++;
    if (cyc !== 11 || e !== 1'b0) begin
      n_fail++; $display("FAIL ack_wait_latency: got %0d err %b want 11 0", cyc, e);
    end
    n_chk++;
    if (nreq - r0 !== 8) begin n_fail++; $display("FAIL ack_wait_req: got %0d want 8", nreq - r0); end
    n_chk++;
    if (lg_addr[a0] !== 32'h8004 || lg_wd[a0] !== 32'h5555) begin
      n_fail++; $display("FAIL ack_wait_xfer: got %h %h want 8004 5555", lg_addr[a0], lg_wd[a0]);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, a0, n0, g;
    logic e, bok;
    rf_set(0, 32'h77); rf_set(1, 32'h88); rf_set(6, 32'h4000);
    ack_dly = 5;
    n0 = nacc;
    @(negedge clock);
    reg_list = 16'h0001; base_sel = 4'd6; base_val = 32'h4000;
    load = 1'b0; up = 1'b1; pre = 1'b0; wb = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    g = 0;
    while (!mem_req && g < 20) begin @(posedge clock); #1; g++; end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || rf_not_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: req %b busy %b nen %b want 0 0 1", mem_req, busy, rf_not_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    ack_dly = 0;
    n_chk++;
    if (nacc !== n0 || rf[6] !== 32'h4000) begin
      n_fail++; $display("FAIL reset_mid_quiet: acc %0d r6 %h want %0d 4000", nacc, rf[6], n0);
    end
    a0 = lg_addr.size();
    launch(16'h0003, 4'd6, 32'h5000, 1'b0, 1'b1, 1'b0, 1'b1, cyc, e, bok);
    n_chk++;
    if (cyc !== 7) begin n_fail++; $display("FAIL restart_latency: got %0d want 7", cyc); end
    n_chk++;
    if (lg_addr[a0] !== 32'h5000 || lg_wd[a0] !== 32'h77 ||
        lg_addr[a0+1] !== 32'h5004 || lg_wd[a0+1] !== 32'h88 || rf[6] !== 32'h5008) begin
      n_fail++;
      $display("FAIL restart_xfer: got %h/%h %h/%h r6 %h want 5000/77 5004/88 5008",
        lg_addr[a0], lg_wd[a0], lg_addr[a0+1], lg_wd[a0+1], rf[6]);
    end
  endtask

  task automatic test_timeout;
    int cyc, r0, w0, n0;
    logic e, bok;
    rf_set(5, 32'h6000);
    ack_dly = -1;
    r0 = nreq; w0 = nwr; n0 = nacc;
    launch(16'h0003, 4'd5, 32'h6000, 1'b1, 1'b1, 1'b0, 1'b1, cyc, e, bok);
    ack_dly = 0;
    n_chk++;
    if (cyc !== 10 || e !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done: got %0d err %b want 10 1", cyc, e);
    end
    n_chk++;
    if (nreq - r0 !== 8) begin n_fail++; $display("FAIL timeout_req: got %0d want 8", nreq - r0); end
    n_chk++;
    if (nwr - w0 !== 0 || nacc !== n0 || rf[5] !== 32'h6000) begin
      n_fail++;
      $display("FAIL timeout_nowrite: wr %0d acc %0d r5 %h want 0 %0d 6000", nwr - w0, nacc, rf[5], n0);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, a0, g;
    logic e, bok;
    rf_set(7, 32'h9000); rf_set(0, 32'h0);
    rd_tab[nacc & 3] = 32'h99;
    a0 = lg_addr.size();
    @(negedge clock);
    g = 0;
    while (busy && g < 50) begin @(negedge clock); g++; end
    reg_list = 16'h0001; base_sel = 4'd7; base_val = 32'h9000;
    load = 1'b1; up = 1'b1; pre = 1'b0; wb = 1'b0; start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      reg_list = 16'hFFFF;
      if (done) break;
    end
    start = 1'b0;
    n_chk++;
    if (cyc !== 4 || lg_addr.size() - a0 !== 1 || rf[0] !== 32'h99) begin
      n_fail++;
      $display("FAIL held_start: cyc %0d xfers %0d r0 %h want 4 1 99", cyc, lg_addr.size() - a0, rf[0]);
    end
    a0 = lg_addr.size();
    launch(16'h8000, 4'd7, 32'hA000, 1'b0, 1'b0, 1'b0, 1'b1, cyc, e, bok);
    n_chk++;
    if (cyc !== 5 || lg_addr[a0] !== 32'hA000 || lg_wd[a0] !== 32'hC0DE_0004) begin
      n_fail++;
      $display("FAIL stm_pc_da: cyc %0d a %h d %h want 5 a000 c0de0004", cyc, lg_addr[a0], lg_wd[a0]);
    end
    n_chk++;
    if (rf[7] !== 32'h9FFC) begin n_fail++; $display("FAIL stm_pc_da_wb: got %h want 9ffc", rf[7]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
    for (int i = 0; i < 4; i++) rd_tab[i] = 32'd0;
    repeat (3) @(negedge clock);
    test_reset;
    test_stm_ia;
    test_ldm_db;
    test_ldm_base_in_list;
    test_empty_list;
    test_ack_wait;
    test_reset_mid;
    test_timeout;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
